// File: rtl/control_in_tracker_pkg.sv
// Shared LC3 opcode constants, tracker FSM state type and opcode classification helpers.
package control_in_tracker_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } trk_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD)  || (op == OP_ST)  || (op == OP_LDR) ||
           (op == OP_STR) || (op == OP_LDI) || (op == OP_STI);
  endfunction

  // Indirect ops make two memory accesses: pointer fetch, then the data itself.
  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/control_in_tracker_ctrl_in_fifo.sv
// Circular in-flight instruction queue with occupancy count, full/empty and dropped-push detect.
module ctrl_in_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_din,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_overflow = i_push && w_full && !w_do_pop;
  assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/control_in_tracker.sv
// LC3 controller-boundary tracker: instruction queue, branch evaluation, memory-op
// completion sequencing with timeout, and sticky protocol-error flags.
module control_in_tracker
  import control_in_tracker_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CC_W    = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  input  logic [DATA_W-1:0]      IMem_dout,
  input  logic                   complete_instr,
  input  logic                   complete_data,
  input  logic [DATA_W-1:0]      IR_Exec,
  input  logic [CC_W-1:0]        NZP,
  input  logic [CC_W-1:0]        psr,
  output logic [DATA_W-1:0]      head_instr,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_full,
  output logic                   q_empty,
  output logic                   br_valid,
  output logic                   br_taken,
  output logic                   mem_busy,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   err_order,
  output logic                   err_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

  trk_state_e        r_state;
  logic [TMR_W-1:0]  r_timer;
  logic              r_indirect;
  logic              r_br_valid;
  logic              r_br_taken;
  logic              r_err_overflow;
  logic              r_err_underflow;
  logic              r_err_order;
  logic              r_err_timeout;

  logic [DATA_W-1:0] w_head;
  logic              w_empty;
  logic              w_overflow;
  logic              w_pop;
  logic [3:0]        w_head_op;
  logic              w_is_br;
  logic              w_busy;
  logic [TMR_W-1:0]  w_timer_next;
  logic              w_tmo_fire;

  assign w_busy    = (r_state != IDLE);
  assign w_pop     = complete_instr && !w_empty && !w_busy;
  assign w_head_op = w_head[DATA_W-1 -: 4];
  // An all-zero word decodes as BR with an empty mask; treat it as a bubble.
  assign w_is_br   = (IR_Exec[DATA_W-1 -: 4] == OP_BR) && (IR_Exec != '0);

  assign w_timer_next = r_timer + 1'b1;
  assign w_tmo_fire   = w_busy && !complete_data && (w_timer_next == TMO);

  ctrl_in_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_push     (fetch_valid),
    .i_din      (IMem_dout),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (q_count),
    .o_full     (q_full),
    .o_empty    (w_empty),
    .o_overflow (w_overflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_indirect <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_pop && is_mem_op(w_head_op)) begin
            r_state    <= WAIT_D1;
            r_indirect <= is_indirect(w_head_op);
          end
        end
        WAIT_D1, WAIT_D2: begin
          if (complete_data) begin
            r_timer <= '0;
            if ((r_state == WAIT_D1) && r_indirect) begin
              r_state <= WAIT_D2;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_tmo_fire) begin
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  // br_taken keeps its last result whenever IR_Exec is not a branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_valid <= 1'b0;
      r_br_taken <= 1'b0;
    end else begin
      r_br_valid <= w_is_br;
      if (w_is_br) begin
        r_br_taken <= |(NZP & psr);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_order     <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      if (w_overflow) begin
        r_err_overflow <= 1'b1;
      end
      if (complete_instr && w_empty) begin
        r_err_underflow <= 1'b1;
      end
      if (complete_instr && !w_empty && w_busy) begin
        r_err_order <= 1'b1;
      end
      if (w_tmo_fire) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign head_instr    = w_head;
  assign q_empty       = w_empty;
  assign mem_busy      = w_busy;
  assign br_valid      = r_br_valid;
  assign br_taken      = r_br_taken;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;
  assign err_order     = r_err_order;
  assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_control_in_tracker.sv
// Directed bench for control_in_tracker: queue wrap/overflow, retire sequencing, timeout, branch, reset.
module tb_control_in_tracker;

  localparam int DATA_W  = 16;
  localparam int CC_W    = 3;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   fetch_valid;
  logic [DATA_W-1:0]      IMem_dout;
  logic                   complete_instr;
  logic                   complete_data;
  logic [DATA_W-1:0]      IR_Exec;
  logic [CC_W-1:0]        NZP;
  logic [CC_W-1:0]        psr;
  logic [DATA_W-1:0]      head_instr;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full;
  logic                   q_empty;
  logic                   br_valid;
  logic                   br_taken;
  logic                   mem_busy;
  logic                   err_overflow;
  logic                   err_underflow;
  logic                   err_order;
  logic                   err_timeout;

  int checks   = 0;
  int failures = 0;

  control_in_tracker #(
    .DATA_W  (DATA_W),
    .CC_W    (CC_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .IMem_dout      (IMem_dout),
    .complete_instr (complete_instr),
    .complete_data  (complete_data),
    .IR_Exec        (IR_Exec),
    .NZP            (NZP),
    .psr            (psr),
    .head_instr     (head_instr),
    .q_count        (q_count),
    .q_full         (q_full),
    .q_empty        (q_empty),
    .br_valid       (br_valid),
    .br_taken       (br_taken),
    .mem_busy       (mem_busy),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow),
    .err_order      (err_order),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst            = 1'b0;
    fetch_valid    = 1'b0;
    IMem_dout      = '0;
    complete_instr = 1'b0;
    complete_data  = 1'b0;
    IR_Exec        = '0;
    NZP            = '0;
    psr            = '0;
    ticks(2);

    // Power-on reset state
    chk("rst_empty",     32'(q_empty),       1);
    chk("rst_full",      32'(q_full),        0);
    chk("rst_count",     32'(q_count),       0);
    chk("rst_head",      32'(head_instr),    0);
    chk("rst_busy",      32'(mem_busy),      0);
    chk("rst_br_valid",  32'(br_valid),      0);
    chk("rst_br_taken",  32'(br_taken),      0);
    chk("rst_ovf",       32'(err_overflow),  0);
    chk("rst_udf",       32'(err_underflow), 0);
    chk("rst_order",     32'(err_order),     0);
    chk("rst_tmo",       32'(err_timeout),   0);
    rst = 1'b1;
    tick();

    // Fill, pop two (ADD then LD), refill across the wrap, then overflow
    fetch_valid = 1'b1;
    IMem_dout = 16'h1111; tick();
    IMem_dout = 16'h2222; tick();
    IMem_dout = 16'h3333; tick();
    IMem_dout = 16'h4444; tick();
    fetch_valid = 1'b0;
    chk("fill_count", 32'(q_count),    4);
    chk("fill_full",  32'(q_full),     1);
    chk("fill_head",  32'(head_instr), 'h1111);
    complete_instr = 1'b1;
    tick();
    chk("pop1_head",  32'(head_instr), 'h2222);
    chk("pop1_busy",  32'(mem_busy),   0);
    tick();
    complete_instr = 1'b0;
    chk("pop2_head",  32'(head_instr), 'h3333);
    chk("pop2_count", 32'(q_count),    2);
    chk("pop2_busy",  32'(mem_busy),   1);
    fetch_valid = 1'b1;
    IMem_dout = 16'h5555; tick();
    IMem_dout = 16'h6666; tick();
    chk("wrap_head",  32'(head_instr),   'h3333);
    chk("wrap_count", 32'(q_count),      4);
    chk("wrap_full",  32'(q_full),       1);
    chk("wrap_ovf",   32'(err_overflow), 0);
    IMem_dout = 16'h7777; tick();
    fetch_valid = 1'b0;
    chk("ovf_flag",   32'(err_overflow), 1);
    chk("ovf_count",  32'(q_count),      4);
    chk("ovf_head",   32'(head_instr),   'h3333);
    complete_data = 1'b1;
    tick();
    complete_data = 1'b0;
    chk("ld_done_busy", 32'(mem_busy),    0);
    chk("ld_done_tmo",  32'(err_timeout), 0);

    // Asynchronous reset clears the sticky overflow without waiting for a clock
    rst = 1'b0;
    #2;
    chk("rst2_ovf",   32'(err_overflow), 0);
    chk("rst2_count", 32'(q_count),      0);
    chk("rst2_head",  32'(head_instr),   0);
    tick();
    rst = 1'b1;

    // Reach WAIT_D2 with three queued, then reset mid-operation
    fetch_valid = 1'b1;
    IMem_dout = 16'hA401; tick();
    IMem_dout = 16'h1042; tick();
    IMem_dout = 16'h5000; tick();
    IMem_dout = 16'h1234; tick();
    IMem_dout = 16'hFFFF; tick();
    fetch_valid = 1'b0;
    chk("t1_ovf", 32'(err_overflow), 1);
    complete_instr = 1'b1;
    tick();
    complete_instr = 1'b0;
    chk("t1_busy",  32'(mem_busy),   1);
    chk("t1_count", 32'(q_count),    3);
    chk("t1_head",  32'(head_instr), 'h1042);
    complete_data = 1'b1;
    tick();
    complete_data = 1'b0;
    chk("t1_d2_busy",  32'(mem_busy), 1);
    chk("t1_d2_count", 32'(q_count),  3);
    rst = 1'b0;
    #2;
    chk("mid_rst_empty", 32'(q_empty),      1);
    chk("mid_rst_count", 32'(q_count),      0);
    chk("mid_rst_head",  32'(head_instr),   0);
    chk("mid_rst_busy",  32'(mem_busy),     0);
    chk("mid_rst_full",  32'(q_full),       0);
    chk("mid_rst_ovf",   32'(err_overflow), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", 32'(mem_busy), 0);

    // Simultaneous push and pop at full with an ADD at the head
    fetch_valid = 1'b1;
    IMem_dout = 16'h1042; tick();
    IMem_dout = 16'hA401; tick();
    IMem_dout = 16'h2005; tick();
    IMem_dout = 16'h1111; tick();
    chk("pp_pre_full", 32'(q_full),     1);
    chk("pp_pre_head", 32'(head_instr), 'h1042);
    IMem_dout = 16'h3007;
    complete_instr = 1'b1;
    tick();
    fetch_valid = 1'b0;
    complete_instr = 1'b0;
    chk("pp_count", 32'(q_count),       4);
    chk("pp_head",  32'(head_instr),    'hA401);
    chk("pp_full",  32'(q_full),        1);
    chk("pp_ovf",   32'(err_overflow),  0);
    chk("pp_udf",   32'(err_underflow), 0);
    chk("pp_order", 32'(err_order),     0);
    chk("pp_busy",  32'(mem_busy),      0);

    // LDI retire: two data strobes five cycles apart; retire attempt while busy
    complete_instr = 1'b1;
    tick();
    chk("ldi_busy",  32'(mem_busy),   1);
    chk("ldi_count", 32'(q_count),    3);
    chk("ldi_head",  32'(head_instr), 'h2005);
    tick();
    complete_instr = 1'b0;
    chk("order_flag",  32'(err_order),     1);
    chk("order_count", 32'(q_count),       3);
    chk("order_head",  32'(head_instr),    'h2005);
    chk("order_udf",   32'(err_underflow), 0);
    complete_data = 1'b1;
    tick();
    complete_data = 1'b0;
    chk("ldi_d1_busy", 32'(mem_busy), 1);
    ticks(4);
    chk("ldi_gap_busy", 32'(mem_busy), 1);
    complete_data = 1'b1;
    tick();
    complete_data = 1'b0;
    chk("ldi_d2_busy", 32'(mem_busy), 0);
    complete_data = 1'b1;
    tick();
    complete_data = 1'b0;
    chk("idle_cd_busy", 32'(mem_busy), 0);
    chk("idle_cd_tmo",  32'(err_timeout), 0);

    // LD retire with no data response runs into the timeout
    complete_instr = 1'b1;
    tick();
    complete_instr = 1'b0;
    chk("ld_busy",  32'(mem_busy),   1);
    chk("ld_head",  32'(head_instr), 'h1111);
    chk("ld_count", 32'(q_count),    2);
    ticks(TIMEOUT - 1);
    chk("tmo_pre_busy", 32'(mem_busy),    1);
    chk("tmo_pre_flag", 32'(err_timeout), 0);
    tick();
    chk("tmo_flag", 32'(err_timeout), 1);
    chk("tmo_busy", 32'(mem_busy),    0);

    // Drain to empty (ST needs a data strobe), then retire on empty with a push
    complete_instr = 1'b1;
    ticks(2);
    complete_instr = 1'b0;
    chk("drain_empty", 32'(q_empty),  1);
    chk("drain_busy",  32'(mem_busy), 1);
    complete_data = 1'b1;
    tick();
    complete_data = 1'b0;
    chk("drain_idle", 32'(mem_busy), 0);
    fetch_valid = 1'b1;
    IMem_dout = 16'h1ABC;
    complete_instr = 1'b1;
    tick();
    fetch_valid = 1'b0;
    complete_instr = 1'b0;
    chk("udf_flag",  32'(err_underflow), 1);
    chk("udf_count", 32'(q_count),       1);
    chk("udf_head",  32'(head_instr),    'h1ABC);
    chk("udf_tmo_sticky", 32'(err_timeout), 1);

    // Branch evaluation: BRnp against several condition codes
    IR_Exec = 16'h0A05;
    NZP = 3'b101;
    psr = 3'b010;
    tick();
    chk("br_z_valid", 32'(br_valid), 1);
    chk("br_z_taken", 32'(br_taken), 0);
    psr = 3'b001;
    tick();
    chk("br_p_valid", 32'(br_valid), 1);
    chk("br_p_taken", 32'(br_taken), 1);
    IR_Exec = 16'h1042;
    psr = 3'b010;
    tick();
    chk("nbr_valid", 32'(br_valid), 0);
    chk("nbr_taken", 32'(br_taken), 1);
    IR_Exec = 16'h0000;
    NZP = 3'b111;
    tick();
    chk("nop_valid", 32'(br_valid), 0);
    chk("nop_taken", 32'(br_taken), 1);
    IR_Exec = 16'h0A05;
    NZP = 3'b101;
    psr = 3'b100;
    tick();
    chk("br_n_valid", 32'(br_valid), 1);
    chk("br_n_taken", 32'(br_taken), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
